// File: rtl/wb_pkg.sv
// Shared state encoding and default sizing for the write buffer controller.
package wb_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DEPTH      = 4;
    localparam int DEF_GAP_CYCLES = 1;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        GAP
    } wb_state_e;

endpackage

// File: rtl/wb_fifo.sv
// Write buffer storage: circular FIFO of address/data pairs with an
// associative lookup that reports the youngest entry matching a read address.
module wb_fifo #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [ADDR_W-1:0]        push_addr_i,
    input  logic [DATA_W-1:0]        push_data_i,
    input  logic                     pop_i,
    input  logic [ADDR_W-1:0]        match_addr_i,
    output logic [ADDR_W-1:0]        head_addr_o,
    output logic [DATA_W-1:0]        head_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     hit_o,
    output logic [DATA_W-1:0]        hit_data_o
);

    localparam int PW = $clog2(DEPTH);

    logic [ADDR_W-1:0] addrMem [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PW-1:0]     rdPtr_q, wrPtr_q;
    logic [PW:0]       count_q;
    logic              doPop;

    assign doPop   = pop_i && (count_q != '0);
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_addr_o = addrMem[rdPtr_q];
    assign head_data_o = dataMem[rdPtr_q];

    always_ff @(posedge clock) begin
        if (push_i) begin
            addrMem[wrPtr_q] <= push_addr_i;
            dataMem[wrPtr_q] <= push_data_i;
        end
    end

    // DEPTH is a power of two, so pointer wrap is just natural overflow.
    always_ff @(posedge clock) begin
        if (!reset) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push_i) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({push_i, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Scan oldest to youngest so the last match seen is the youngest one.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        hit_o      = 1'b0;
        hit_data_o = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rdPtr_q + PW'(k);
            if (((PW+1)'(k) < count_q) && (addrMem[idx] == match_addr_i)) begin
                hit_o      = 1'b1;
                hit_data_o = dataMem[idx];
            end
        end
    end

endmodule

// File: rtl/write_buffer_ctl.sv
// CPU-side write buffer controller that drains posted writes to memory.
// Define WB_FWD_EN to forward buffered data to matching reads instead of draining.
module write_buffer_ctl
    import wb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_waddr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    input  logic                     cpu_re,
    input  logic [ADDR_W-1:0]        cpu_raddr,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic                     cpu_stall,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    output logic                     mem_ctl_we,
    input  logic                     mem_miss,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [$clog2(DEPTH):0]   buf_count
);

`ifdef WB_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    wb_state_e         state_q, state_d;
    logic [GW-1:0]     gapCnt_q, gapCnt_d;
    logic [ADDR_W-1:0] lastAddr_q;

    logic              push, pop, full, empty, hit, hazard, drain, rdStall;
    logic [ADDR_W-1:0] headAddr;
    logic [DATA_W-1:0] headData, hitData;

    wb_fifo #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_addr_i  (cpu_waddr),
        .push_data_i  (cpu_wdata),
        .pop_i        (pop),
        .match_addr_i (cpu_raddr),
        .head_addr_o  (headAddr),
        .head_data_o  (headData),
        .count_o      (buf_count),
        .full_o       (full),
        .empty_o      (empty),
        .hit_o        (hit),
        .hit_data_o   (hitData)
    );

    // A write only needs buffer space; a stalled read alongside it does not block it.
    assign push      = reset && cpu_we && !full;
    assign hazard    = cpu_re && hit;
    assign drain     = !empty && (!cpu_re || full || (hazard && !FWD_EN));
    assign mem_wdata = headData;
    assign cpu_stall = reset && (rdStall || (cpu_we && full));

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= IDLE;
            gapCnt_q   <= '0;
            lastAddr_q <= '0;
        end else begin
            state_q  <= state_d;
            gapCnt_q <= gapCnt_d;
            if (pop) lastAddr_q <= headAddr;
        end
    end

    always_comb begin
        state_d    = state_q;
        gapCnt_d   = gapCnt_q;
        mem_ctl_we = 1'b0;
        mem_addr   = cpu_raddr;
        cpu_rdata  = mem_rdata;
        pop        = 1'b0;
        rdStall    = 1'b0;
        case (state_q)
            IDLE: begin
                if (drain) begin
                    mem_ctl_we = 1'b1;
                    mem_addr   = headAddr;
                    rdStall    = cpu_re;
                    state_d    = WRITE;
                end else if (FWD_EN && hazard) begin
                    cpu_rdata = hitData;
                end else begin
                    rdStall = cpu_re && mem_miss;
                end
            end
            WRITE: begin
                mem_ctl_we = 1'b1;
                mem_addr   = headAddr;
                rdStall    = cpu_re;
                if (!mem_miss) begin
                    pop      = 1'b1;
                    gapCnt_d = '0;
                    state_d  = GAP;
                end
            end
            GAP: begin
                mem_addr = lastAddr_q;
                rdStall  = cpu_re;
                if (gapCnt_q == GW'(GAP_CYCLES - 1)) begin
                    gapCnt_d = '0;
                    state_d  = IDLE;
                end else begin
                    gapCnt_d = gapCnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset quiesces the memory side immediately, even mid-drain.
        if (!reset) begin
            state_d    = IDLE;
            gapCnt_d   = '0;
            mem_ctl_we = 1'b0;
            mem_addr   = cpu_raddr;
            cpu_rdata  = mem_rdata;
            pop        = 1'b0;
            rdStall    = 1'b0;
        end
    end

endmodule

// File: tb/tb_write_buffer_ctl.sv
// Directed bench for write_buffer_ctl; a second instance with GAP_CYCLES=3
// shares the stimulus so the turnaround length can be observed.
module tb_write_buffer_ctl;

    logic        clock, reset;
    logic        cpu_we, cpu_re, mem_miss;
    logic [31:0] cpu_waddr, cpu_wdata, cpu_raddr, mem_rdata;

    logic [31:0] cpu_rdata, mem_addr, mem_wdata;
    logic        cpu_stall, mem_ctl_we;
    logic [2:0]  buf_count;

    logic [31:0] g3Rdata, g3Addr, g3Wdata;
    logic        g3Stall, g3We;
    logic [2:0]  g3Count;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] MEMDATA = 32'hCAFE_0001;

    write_buffer_ctl #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .GAP_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ctl_we(mem_ctl_we), .mem_miss(mem_miss), .mem_rdata(mem_rdata),
        .buf_count(buf_count)
    );

    write_buffer_ctl #(.ADDR_W(32), .DATA_W(32), .DEPTH(4), .GAP_CYCLES(3)) dutG3 (
        .clock(clock), .reset(reset),
        .cpu_we(cpu_we), .cpu_waddr(cpu_waddr), .cpu_wdata(cpu_wdata),
        .cpu_re(cpu_re), .cpu_raddr(cpu_raddr), .cpu_rdata(g3Rdata),
        .cpu_stall(g3Stall), .mem_addr(g3Addr), .mem_wdata(g3Wdata),
        .mem_ctl_we(g3We), .mem_miss(mem_miss), .mem_rdata(mem_rdata),
        .buf_count(g3Count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Inputs change just after a rising edge; checks happen at the following falling edge.
    task automatic applyStimulus(input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                                 input logic re, input logic [31:0] raddr, input logic miss);
        cpu_we    = we;
        cpu_waddr = waddr;
        cpu_wdata = wdata;
        cpu_re    = re;
        cpu_raddr = raddr;
        mem_miss  = miss;
        @(negedge clock);
    endtask

    task automatic applyReset();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        nextCycle();
        nextCycle();
        reset = 1'b1;
    endtask

    initial begin
        reset     = 1'b0;
        mem_rdata = MEMDATA;
        cpu_we = 0; cpu_re = 0; mem_miss = 0;
        cpu_waddr = 0; cpu_wdata = 0; cpu_raddr = 0;
        nextCycle();
        nextCycle();

        // Outputs held in reset even with requests present
        applyStimulus(1, 32'h10, 32'h1, 1, 32'h55, 1);
        checkOutput("rst_count", buf_count, 0);
        checkOutput("rst_we", mem_ctl_we, 0);
        checkOutput("rst_stall", cpu_stall, 0);
        checkOutput("rst_addr", mem_addr, 32'h55);
        checkOutput("rst_rdata", cpu_rdata, MEMDATA);
        nextCycle();
        checkOutput("rst_nopush", buf_count, 0);
        reset = 1'b1;

        // Single write drains, then GAP; the GAP_CYCLES=3 copy holds off the read longer
        applyStimulus(1, 32'h100, 32'hAA, 0, 32'h44, 0);
        checkOutput("w1_stall", cpu_stall, 0);
        checkOutput("w1_we_before", mem_ctl_we, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 32'h44, 0);
        checkOutput("w1_count", buf_count, 1);
        checkOutput("w1_we", mem_ctl_we, 1);
        checkOutput("w1_addr", mem_addr, 32'h100);
        checkOutput("w1_wdata", mem_wdata, 32'hAA);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h44, 0);
        checkOutput("w1_write_we", mem_ctl_we, 1);
        checkOutput("w1_write_stall", cpu_stall, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h44, 0);
        checkOutput("w1_gap_we", mem_ctl_we, 0);
        checkOutput("w1_gap_addr", mem_addr, 32'h100);
        checkOutput("w1_gap_stall", cpu_stall, 1);
        checkOutput("w1_gap_count", buf_count, 0);
        checkOutput("g3_gap1_stall", g3Stall, 1);
        checkOutput("g3_gap1_we", g3We, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h44, 0);
        checkOutput("w1_idle_stall", cpu_stall, 0);
        checkOutput("w1_idle_addr", mem_addr, 32'h44);
        checkOutput("w1_idle_rdata", cpu_rdata, MEMDATA);
        checkOutput("g3_gap2_stall", g3Stall, 1);
        checkOutput("g3_gap2_addr", g3Addr, 32'h100);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h44, 0);
        checkOutput("g3_gap3_stall", g3Stall, 1);
        checkOutput("g3_gap3_we", g3We, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h44, 0);
        checkOutput("g3_idle_stall", g3Stall, 0);
        checkOutput("g3_idle_addr", g3Addr, 32'h44);

        // Five back-to-back writes against a busy memory
        applyReset();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 32'h10 + i, 32'hD0 + i, 0, 0, 1);
            checkOutput($sformatf("full_count%0d", i), buf_count, (i < 4) ? i : 4);
            checkOutput($sformatf("full_stall%0d", i), cpu_stall, (i == 4) ? 1 : 0);
            nextCycle();
        end
        applyStimulus(1, 32'h14, 32'hD4, 0, 0, 1);
        checkOutput("full_hold_count", buf_count, 4);
        checkOutput("full_hold_head", mem_addr, 32'h10);
        nextCycle();
        applyStimulus(1, 32'h14, 32'hD4, 0, 0, 0);
        checkOutput("full_pop_stall", cpu_stall, 1);
        checkOutput("full_pop_count", buf_count, 4);
        nextCycle();
        applyStimulus(1, 32'h14, 32'hD4, 0, 0, 0);
        checkOutput("full_accept_stall", cpu_stall, 0);
        checkOutput("full_accept_count", buf_count, 3);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("full_refill_count", buf_count, 4);
        checkOutput("full_next_head", mem_addr, 32'h11);
        checkOutput("full_next_we", mem_ctl_we, 1);

        // Reset in the middle of a drain with three entries queued
        applyReset();
        applyStimulus(1, 32'hA0, 32'h1, 0, 0, 1);
        nextCycle();
        applyStimulus(1, 32'hA1, 32'h2, 0, 0, 1);
        nextCycle();
        applyStimulus(1, 32'hA2, 32'h3, 0, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 0, 32'h77, 1);
        checkOutput("mid_count", buf_count, 3);
        checkOutput("mid_we", mem_ctl_we, 1);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 32'h77, 1);
        checkOutput("mid_rst_we", mem_ctl_we, 0);
        checkOutput("mid_rst_addr", mem_addr, 32'h77);
        nextCycle();
        reset = 1'b1;
        applyStimulus(0, 0, 0, 1, 32'h77, 0);
        checkOutput("mid_after_count", buf_count, 0);
        checkOutput("mid_after_we", mem_ctl_we, 0);
        checkOutput("mid_after_stall", cpu_stall, 0);

        // Read hitting a buffered address
        applyReset();
        applyStimulus(1, 32'h200, 32'hBB, 1, 32'h900, 0);
        checkOutput("haz_prior_stall", cpu_stall, 0);
        checkOutput("haz_prior_rdata", cpu_rdata, MEMDATA);
        nextCycle();
`ifdef WB_FWD_EN
        applyStimulus(0, 0, 0, 1, 32'h200, 0);
        checkOutput("fwd_stall", cpu_stall, 0);
        checkOutput("fwd_rdata", cpu_rdata, 32'hBB);
        checkOutput("fwd_we", mem_ctl_we, 0);
        checkOutput("fwd_count", buf_count, 1);
`else
        applyStimulus(0, 0, 0, 1, 32'h200, 0);
        checkOutput("haz_drain_stall", cpu_stall, 1);
        checkOutput("haz_drain_we", mem_ctl_we, 1);
        checkOutput("haz_drain_addr", mem_addr, 32'h200);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h200, 0);
        checkOutput("haz_write_stall", cpu_stall, 1);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h200, 0);
        checkOutput("haz_gap_stall", cpu_stall, 1);
        checkOutput("haz_gap_count", buf_count, 0);
        nextCycle();
        applyStimulus(0, 0, 0, 1, 32'h200, 0);
        checkOutput("haz_read_stall", cpu_stall, 0);
        checkOutput("haz_read_addr", mem_addr, 32'h200);
        checkOutput("haz_read_rdata", cpu_rdata, MEMDATA);
`endif

        // Unrelated reads keep the buffer waiting until it fills
        applyReset();
        applyStimulus(1, 32'h300, 32'h30, 1, 32'h400, 0);
        nextCycle();
        for (int i = 1; i < 4; i++) begin
            applyStimulus(1, 32'h300 + i, 32'h30 + i, 1, 32'h400, 0);
            checkOutput($sformatf("rd_stall%0d", i), cpu_stall, 0);
            checkOutput($sformatf("rd_addr%0d", i), mem_addr, 32'h400);
            checkOutput($sformatf("rd_we%0d", i), mem_ctl_we, 0);
            checkOutput($sformatf("rd_count%0d", i), buf_count, i);
            nextCycle();
        end
        applyStimulus(0, 0, 0, 1, 32'h400, 0);
        checkOutput("rd_full_we", mem_ctl_we, 1);
        checkOutput("rd_full_addr", mem_addr, 32'h300);
        checkOutput("rd_full_stall", cpu_stall, 1);
        checkOutput("rd_full_count", buf_count, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/write_buffer_ctl.md
WRITE_BUFFER_CTL -- requirements
Module: write_buffer_ctl

Interface
REQ-001 The block SHALL provide parameters, one per line:
  ADDR_W, 32, address width
  DATA_W, 32, data width
  DEPTH, 4, buffer entries (power of 2, >=2)
  GAP_CYCLES, 1, read-after-write turnaround cycles (>=1)
REQ-002 The block SHALL provide ports, one per line:
  clock  in  1  sole clock, rising edge
  reset  in  1  synchronous, active-low reset
  cpu_we  in  1  write request
  cpu_waddr  in  ADDR_W  write address
  cpu_wdata  in  DATA_W  write data
  cpu_re  in  1  read request
  cpu_raddr  in  ADDR_W  read address
  cpu_rdata  out  DATA_W  read data to CPU
  cpu_stall  out  1  request not accepted this cycle; hold request
  mem_addr  out  ADDR_W  memory address
  mem_wdata  out  DATA_W  memory write data
  mem_ctl_we  out  1  memory write enable
  mem_miss  in  1  memory busy; access not complete
  mem_rdata  in  DATA_W  memory read data
  buf_count  out  $clog2(DEPTH)+1  valid entries
REQ-003 One clock; reset is synchronous and active-low.

Function
REQ-010 The buffer SHALL be a FIFO; a write is accepted (pushed) when cpu_we=1 and cpu_stall=0; pushed data becomes visible the next cycle.
REQ-011 The FSM SHALL have states IDLE, WRITE and GAP.
REQ-012 In IDLE: if buffer non-empty and (cpu_re=0 or buf_count=DEPTH or read hazard), then mem_addr/mem_wdata=head, mem_ctl_we=1, next=WRITE; otherwise mem_addr=cpu_raddr, mem_ctl_we=0, next=IDLE.
REQ-013 In WRITE: mem_addr/mem_wdata=head, mem_ctl_we=1; when mem_miss=0 the head is popped and next=GAP; else stay.
REQ-014 In GAP: mem_ctl_we=0, mem_addr=last written address; a counter stays GAP_CYCLES cycles, then next=IDLE.
REQ-015 Reads are served only in IDLE with mem_ctl_we=0; cpu_rdata=mem_rdata; cpu_stall=1 while mem_miss=1.
REQ-016 cpu_re in WRITE or GAP SHALL assert cpu_stall.
REQ-017 Read hazard = cpu_re=1 and cpu_raddr equals the address of any valid entry.
REQ-018 cpu_we while buf_count=DEPTH SHALL assert cpu_stall, including a cycle that also pops; no push.
REQ-019 cpu_we and cpu_re together: the write is accepted independently of the read stall when not full.
REQ-020 buf_count SHALL change by +1, -1 or 0 (push and pop together); pointers wrap modulo DEPTH.

Reset
REQ-030 With reset=0 at a clock edge: state=IDLE, buffer empty, buf_count=0, gap counter=0.
REQ-031 While reset=0: mem_ctl_we=0, cpu_stall=0, mem_addr=cpu_raddr, cpu_rdata=mem_rdata.
REQ-032 Reset in WRITE or GAP SHALL discard all buffered entries, with no further memory write.

Configuration
REQ-040 With WB_FWD_EN defined, a read hazard in IDLE SHALL return the youngest matching entry's data on cpu_rdata the same cycle, with cpu_stall=0 and no drain forced.
REQ-041 Without WB_FWD_EN, a read hazard SHALL stall the read until no matching entry remains.

Structure
REQ-050 Package wb_pkg SHALL hold the state enum typedef (IDLE/WRITE/GAP) and the default parameter constants.
REQ-051 Storage, pointers, count and address-match logic SHALL be sub-module wb_fifo; the FSM stays in write_buffer_ctl.

Verification
REQ-060 Reset mid-WRITE with 3 entries -> next cycle buf_count=0, mem_ctl_we=0, state IDLE.
REQ-061 Push 0x100/0xAA with mem_miss=0, no reads -> mem_ctl_we=1 with addr 0x100 one cycle later, GAP 1 cycle, IDLE, buf_count=0.
REQ-062 DEPTH=4: 5 back-to-back writes with mem_miss=1 -> 5th stalled, buf_count=4; release mem_miss -> 5th accepted once an entry pops.
REQ-063 Buffer holds 0x200; cpu_re 0x200 -> without WB_FWD_EN stall through drain+GAP, then read memory; with WB_FWD_EN cpu_rdata=buffered data, no stall.
REQ-064 Buffer holds 0x300; continuous cpu_re 0x400 -> reads served, buffer waits; on filling to DEPTH, drain preempts the read.
REQ-065 GAP_CYCLES=3: single write -> exactly 3 GAP cycles with mem_ctl_we=0 before the next read is served.
